// File: rtl/spectrum_peak_picker_pkg.sv
// Shared types and band table for the spectrum peak picker.
package spectrum_pkg;

    localparam int unsigned N_BINS    = 512;
    localparam int unsigned BIN_W     = $clog2(N_BINS);
    localparam int unsigned NUM_BANDS = 6;
    localparam int unsigned BAND_W    = 3;
    localparam int unsigned MAG_WIDTH = 16;

    typedef logic [BIN_W-1:0] bin_t;

    // Logarithmic band edges, inclusive.
    localparam bin_t BAND_START [NUM_BANDS] = '{9'd0, 9'd10, 9'd20, 9'd40, 9'd80,  9'd160};
    localparam bin_t BAND_END   [NUM_BANDS] = '{9'd9, 9'd19, 9'd39, 9'd79, 9'd159, 9'd511};

    typedef struct packed {
        logic [MAG_WIDTH-1:0] mag;
        bin_t                 bin;
    } band_peak_t;

    typedef band_peak_t [NUM_BANDS-1:0] band_bank_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } emit_state_e;

    // Band containing a bin; the top band is the fallback so the last
    // band's upper edge never needs an explicit compare.
    function automatic logic [BAND_W-1:0] band_of(input bin_t bin);
        logic [BAND_W-1:0] band;
        band = BAND_W'(NUM_BANDS - 1);
        for (int unsigned k = 0; k < NUM_BANDS - 1; k++) begin
            if (bin <= BAND_END[NUM_BANDS - 2 - k]) begin
                band = BAND_W'(NUM_BANDS - 2 - k);
            end
        end
        return band;
    endfunction

    // Accumulator contents at the start of every frame.
    function automatic band_bank_t cleared_bank();
        band_bank_t bank;
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
            bank[b].mag = '0;
            bank[b].bin = BAND_START[b];
        end
        return bank;
    endfunction

endpackage

// File: rtl/spectrum_peak_picker_if.sv
// Peak stream from the picker to the fingerprint hasher.
interface spectrum_peak_picker_if #(
    parameter int unsigned MAG_W   = 16,
    parameter int unsigned FRAME_W = 16
);
    logic               peak_valid_o;
    logic               peak_ready_i;
    logic [2:0]         peak_band_o;
    logic [8:0]         peak_bin_o;
    logic [MAG_W-1:0]   peak_mag_o;
    logic [FRAME_W-1:0] peak_frame_o;
    logic               peak_last_o;

    modport master (
        output peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o, peak_frame_o, peak_last_o,
        input  peak_ready_i
    );

    modport slave (
        input  peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o, peak_frame_o, peak_last_o,
        output peak_ready_i
    );
endinterface

// File: rtl/spectrum_peak_picker_emitter.sv
// Shadow bank plus the scan/emit FSM that streams one peak per qualifying band.
module peak_emitter #(
    parameter int unsigned MAG_W   = 16,
    parameter int unsigned FRAME_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  spectrum_pkg::band_bank_t bank,
    input  logic [MAG_W-1:0]        threshold_i,
    spectrum_peak_picker_if.master  peak,
    output logic                    busy_o,
    output logic                    overrun_o
);
    import spectrum_pkg::*;

    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

    emit_state_e        state_q, state_d;
    logic [BAND_W-1:0]  band_q, band_d;
    band_bank_t         shadow_q;
    logic [MAG_W-1:0]   thr_q;
    logic [FRAME_W-1:0] frame_cnt_q, frame_tag_q;
    logic               overrun_q;
    logic [NUM_BANDS-1:0] qual;
    logic               capture;
    logic               more_above;

    // Which shadow bands reach the captured threshold, and whether any lie above the current one.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
            qual[b] = (shadow_q[b].mag >= thr_q);
        end
        more_above = |((qual >> band_q) >> 1);
    end

    // Next-state logic; a frame load preempts any scan or pending beat.
    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        capture = 1'b0;
        if (load) begin
            state_d = SCAN;
            band_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                SCAN: begin
                    if (qual[band_q]) begin
                        state_d = EMIT;
                        capture = 1'b1;
                    end else if (band_q == LAST_BAND) begin
                        state_d = IDLE;
                    end else begin
                        band_d = band_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (peak.peak_ready_i) begin
                        if (band_q == LAST_BAND) begin
                            state_d = IDLE;
                        end else begin
                            state_d = SCAN;
                            band_d  = band_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            band_q  <= '0;
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
        end
    end

    // Frame-end capture of the bank, threshold and frame tag; overrun is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= cleared_bank();
            thr_q       <= '0;
            frame_cnt_q <= '0;
            frame_tag_q <= '0;
            overrun_q   <= 1'b0;
        end else if (load) begin
            shadow_q    <= bank;
            thr_q       <= threshold_i;
            frame_tag_q <= frame_cnt_q;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            if (state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Beat payload, registered on entry to EMIT and held until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak.peak_band_o  <= '0;
            peak.peak_bin_o   <= '0;
            peak.peak_mag_o   <= '0;
            peak.peak_frame_o <= '0;
            peak.peak_last_o  <= 1'b0;
        end else if (capture) begin
            peak.peak_band_o  <= band_q;
            peak.peak_bin_o   <= shadow_q[band_q].bin;
            peak.peak_mag_o   <= shadow_q[band_q].mag;
            peak.peak_frame_o <= frame_tag_q;
            peak.peak_last_o  <= ~more_above;
        end
    end

    assign peak.peak_valid_o = (state_q == EMIT);
    assign busy_o            = (state_q != IDLE);
    assign overrun_o         = overrun_q;

endmodule

// File: rtl/spectrum_peak_picker.sv
// Reads FFT magnitudes bin by bin, tracks per-band maxima and hands each frame to the emitter.
module spectrum_peak_picker #(
    parameter int unsigned N_BINS  = 512,
    parameter int unsigned MAG_W   = 16,
    parameter int unsigned FRAME_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [$clog2(N_BINS)-1:0] bin_index_o,
    input  logic [MAG_W-1:0]          mag_i,
    input  logic                      mag_valid_i,
    input  logic [MAG_W-1:0]          threshold_i,
    spectrum_peak_picker_if.master    peak,
    output logic                      frame_done_o,
    output logic                      overrun_o,
    output logic                      busy_o
);
    import spectrum_pkg::*;

    localparam int unsigned BW = $clog2(N_BINS);

    logic [BW-1:0]     idx_q;
    band_bank_t        acc_q, folded;
    logic [BAND_W-1:0] cur_band;
    logic              frame_end;
    logic              frame_done_q;

    assign cur_band  = band_of(idx_q);
    assign frame_end = mag_valid_i && (idx_q == BW'(N_BINS - 1));

    // Accumulators with the current sample applied; strict compare keeps the lowest bin on ties.
    always_comb begin
        folded = acc_q;
        if (mag_valid_i && (mag_i > acc_q[cur_band].mag)) begin
            folded[cur_band].mag = mag_i;
            folded[cur_band].bin = idx_q;
        end
    end

    // Index counter and accumulators; the frame-end sample goes only to the shadow copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            acc_q <= cleared_bank();
        end else if (mag_valid_i) begin
            idx_q <= idx_q + 1'b1;
            acc_q <= frame_end ? cleared_bank() : folded;
        end
    end

    // Frame-done pulse, one cycle after the last bin is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
        end
    end

    peak_emitter #(
        .MAG_W   (MAG_W),
        .FRAME_W (FRAME_W)
    ) u_emitter (
        .clk         (clk),
        .reset       (reset),
        .load        (frame_end),
        .bank        (folded),
        .threshold_i (threshold_i),
        .peak        (peak),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    assign bin_index_o  = idx_q;
    assign frame_done_o = frame_done_q;

endmodule
